// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_pkg
// Description : Shared types and constants for the 2-channel deserialiser.
//               Holds the framing state enum, the default word width and
//               the pair-counter width derived from it.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PAR  = 2'd2
    } state_t;

    // Pair-counter width for an arbitrary word width (never narrower than 1).
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_2ch_deser_if.sv
`default_nettype none
// ============================================================================
// Module      : demux_2ch_deser_if
// Description : Serial-in / parallel-out bus of the 2-channel deserialiser.
//               master : drives in_bit, in_valid, sof; observes the outputs
//               slave  : the deserialiser (consumes the stream, drives
//                        out_a, out_b, out_valid, err_a, err_b, sel)
// Revision    : 1.0 - initial release
// ============================================================================
interface demux_2ch_deser_if
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             in_bit;
    logic             in_valid;
    logic             sof;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic             out_valid;
    logic             err_a;
    logic             err_b;
    logic             sel;

    modport master (
        output in_bit, in_valid, sof,
        input  out_a, out_b, out_valid, err_a, err_b, sel
    );

    modport slave (
        input  in_bit, in_valid, sof,
        output out_a, out_b, out_valid, err_a, err_b, sel
    );

endinterface : demux_2ch_deser_if
`default_nettype wire

// File: rtl/demux_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : demux_shift_reg
// Description : WIDTH-bit MSB-first shift register with enable and a
//               synchronous clear. New bits enter at the LSB so the first
//               bit shifted in ends up as the MSB after WIDTH shifts.
// Ports       : clk, rst (async, active-high), clr (sync clear; when
//               combined with en the register restarts holding only d),
//               en (shift enable), d (serial in), q (parallel word)
// Revision    : 1.0 - initial release
// ============================================================================
module demux_shift_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clr,
    input  wire logic             en,
    input  wire logic             d,
    output logic      [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= en ? {{(WIDTH-1){1'b0}}, d} : '0;
        end else if (en) begin
            r_q <= {r_q[WIDTH-2:0], d};
        end
    end

    assign q = r_q;

endmodule : demux_shift_reg
`default_nettype wire

// File: rtl/demux_2ch_deser.sv
`default_nettype none
// ============================================================================
// Module      : demux_2ch_deser
// Description : Receive side of the 2-to-1 serial mux. Splits one
//               interleaved bit stream (A,B,A,B,...) into two WIDTH-bit
//               words, MSB first, framed by sof. A completed frame is
//               presented on out_a/out_b with a one-cycle out_valid pulse
//               one clock after its last bit.
// Ports       : clk, rst (async, active-high), bus (demux_2ch_deser_if.slave:
//               in_bit, in_valid, sof in; out_a, out_b, out_valid, err_a,
//               err_b, sel out)
// Options     : DEMUX_PARITY_EN - each data frame is followed by an A and a
//               B even-parity bit; err_a/err_b report mismatches. Without it
//               err_a/err_b are constant 0.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_2ch_deser
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  wire logic        clk,
    input  wire logic        rst,
    demux_2ch_deser_if.slave bus
);

    localparam int             CW     = cnt_width(WIDTH);
    localparam logic [CW-1:0]  c_last = CW'(WIDTH - 1);

    state_t           r_state, w_state_nxt;
    logic             r_sel, w_sel_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_done, w_done_nxt;
    logic             w_clr, w_en_a, w_en_b;
    logic [WIDTH-1:0] w_word_a, w_word_b;
    logic [WIDTH-1:0] r_out_a, r_out_b;
    logic             r_out_valid;

    // ------------------------------------------------------------------
    // Channel shift registers
    // ------------------------------------------------------------------
    demux_shift_reg #(.WIDTH(WIDTH)) u_shift_a (
        .clk (clk),
        .rst (rst),
        .clr (w_clr),
        .en  (w_en_a),
        .d   (bus.in_bit),
        .q   (w_word_a)
    );

    demux_shift_reg #(.WIDTH(WIDTH)) u_shift_b (
        .clk (clk),
        .rst (rst),
        .clr (w_clr),
        .en  (w_en_b),
        .d   (bus.in_bit),
        .q   (w_word_b)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and slot decode
    // ------------------------------------------------------------------
`ifdef DEMUX_PARITY_EN
    logic w_par_a_en, w_par_b_en;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_clr       = 1'b0;
        w_en_a      = 1'b0;
        w_en_b      = 1'b0;
`ifdef DEMUX_PARITY_EN
        w_par_a_en  = 1'b0;
        w_par_b_en  = 1'b0;
`endif
        if (bus.in_valid && bus.sof) begin
            // Restart from any state: drop the partial frame and take this
            // bit as the A-channel MSB.
            w_clr       = 1'b1;
            w_en_a      = 1'b1;
            w_sel_nxt   = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = RUN;
        end else if (bus.in_valid) begin
            case (r_state)
                IDLE: begin
                    // Unframed bits are dropped.
                end
                RUN: begin
                    if (!r_sel) begin
                        w_en_a    = 1'b1;
                        w_sel_nxt = 1'b1;
                    end else begin
                        w_en_b    = 1'b1;
                        w_sel_nxt = 1'b0;
                        if (r_cnt == c_last) begin
                            w_cnt_nxt = '0;
`ifdef DEMUX_PARITY_EN
                            w_state_nxt = PAR;
`else
                            w_done_nxt  = 1'b1;
`endif
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end
`ifdef DEMUX_PARITY_EN
                PAR: begin
                    if (!r_sel) begin
                        w_par_a_en = 1'b1;
                        w_sel_nxt  = 1'b1;
                    end else begin
                        w_par_b_en  = 1'b1;
                        w_sel_nxt   = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = RUN;
                    end
                end
`endif
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Select, pair counter and frame-complete flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel  <= 1'b0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_sel  <= w_sel_nxt;
            r_cnt  <= w_cnt_nxt;
            r_done <= w_done_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Output words: loaded on the edge after the frame's last bit. The
    // shift registers may already be taking the next frame's first bit on
    // that same edge; the non-blocking read still sees the finished word.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_a     <= '0;
            r_out_b     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_done;
            if (r_done) begin
                r_out_a <= w_word_a;
                r_out_b <= w_word_b;
            end
        end
    end

`ifdef DEMUX_PARITY_EN
    logic r_par_a, r_par_b;
    logic r_err_a, r_err_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par_a <= 1'b0;
            r_par_b <= 1'b0;
            r_err_a <= 1'b0;
            r_err_b <= 1'b0;
        end else begin
            if (w_par_a_en) begin
                r_par_a <= bus.in_bit;
            end
            if (w_par_b_en) begin
                r_par_b <= bus.in_bit;
            end
            // Even parity: word XOR parity bit must be 0.
            if (r_done) begin
                r_err_a <= (^w_word_a) ^ r_par_a;
                r_err_b <= (^w_word_b) ^ r_par_b;
            end
        end
    end

    assign bus.err_a = r_err_a;
    assign bus.err_b = r_err_b;
`else
    assign bus.err_a = 1'b0;
    assign bus.err_b = 1'b0;
`endif

    assign bus.out_a     = r_out_a;
    assign bus.out_b     = r_out_b;
    assign bus.out_valid = r_out_valid;
    assign bus.sel       = r_sel;

endmodule : demux_2ch_deser
`default_nettype wire

// File: tb/tb_demux_2ch_deser.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_2ch_deser
// Description : Directed self-checking bench for demux_2ch_deser (WIDTH=8).
//               Inputs change and outputs are sampled on the falling edge.
//               A monitor logs every out_valid pulse for later comparison.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_2ch_deser;

    localparam int W = 8;

    logic clk;
    logic rst;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [W-1:0] q_a[$];
    logic [W-1:0] q_b[$];
    logic         q_ea[$];
    logic         q_eb[$];

    demux_2ch_deser_if #(.WIDTH(W)) bus ();

    demux_2ch_deser #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse logger
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            q_a.push_back(bus.out_a);
            q_b.push_back(bus.out_b);
            q_ea.push_back(bus.err_a);
            q_eb.push_back(bus.err_b);
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        q_a.delete();
        q_b.delete();
        q_ea.delete();
        q_eb.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.sof      = 1'b0;
            bus.in_bit   = 1'b0;
        end
    endtask

    task automatic send_bit(input logic b, input logic s);
        @(negedge clk);
        bus.in_bit   = b;
        bus.in_valid = 1'b1;
        bus.sof      = s;
    endtask

    // Interleaved frame A7,B7,A6,B6,...; a 3-cycle gap follows bit numbers
    // g1 and g2 (1-based, 0 = none). Parity bits are appended when enabled.
    task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                              input int g1, input int g2, input logic pa, input logic pb);
        int n;
        n = 0;
        for (int i = W - 1; i >= 0; i--) begin
            send_bit(a[i], s && (i == W - 1));
            n++;
            if (n == g1 || n == g2) idle(3);
            send_bit(b[i], 1'b0);
            n++;
            if (n == g1 || n == g2) idle(3);
        end
`ifdef DEMUX_PARITY_EN
        send_bit(pa, 1'b0);
        send_bit(pb, 1'b0);
`else
        if (pa === 1'bx || pb === 1'bx) idle(0);
`endif
    endtask

    task automatic check_pulse(input string tag, input int idx, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic ea, input logic eb);
        check({tag, "_a"},   q_a[idx],  a);
        check({tag, "_b"},   q_b[idx],  b);
        check({tag, "_ea"},  q_ea[idx], ea);
        check({tag, "_eb"},  q_eb[idx], eb);
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_bit   = 1'b0;
        bus.in_valid = 1'b0;
        bus.sof      = 1'b0;

        // ---------------- reset state ----------------
        idle(2);
        check("rst_out_a",     bus.out_a,     8'h00);
        check("rst_out_b",     bus.out_b,     8'h00);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_err",       {bus.err_a, bus.err_b}, 2'b00);
        check("rst_sel",       bus.sel,       1'b0);
        rst = 1'b0;
        idle(2);
        clear_log();

        // ---------------- basic frame with latency ----------------
        send_frame(8'hA5, 8'h3C, 1'b1, 0, 0, ^8'hA5, ^8'h3C);
        idle(1);                                  // just after last-bit edge
        check("lat_early_valid", bus.out_valid, 1'b0);
        check("lat_sel_back_a",  bus.sel,       1'b0);
        idle(1);                                  // one clock later
        check("lat_valid",       bus.out_valid, 1'b1);
        check("lat_out_a",       bus.out_a,     8'hA5);
        check("lat_out_b",       bus.out_b,     8'h3C);
        idle(1);
        check("lat_pulse_end",   bus.out_valid, 1'b0);
        check("lat_hold_a",      bus.out_a,     8'hA5);
        idle(2);
        check("basic_count", q_a.size(), 1);
        check_pulse("basic", 0, 8'hA5, 8'h3C, 1'b0, 1'b0);
        clear_log();

        // ---------------- back-to-back frames ----------------
        send_frame(8'h01, 8'h80, 1'b1, 0, 0, ^8'h01, ^8'h80);
        send_frame(8'hFF, 8'h00, 1'b0, 0, 0, ^8'hFF, ^8'h00);
        idle(3);
        check("b2b_count", q_a.size(), 2);
        check_pulse("b2b_f1", 0, 8'h01, 8'h80, 1'b0, 1'b0);
        check_pulse("b2b_f2", 1, 8'hFF, 8'h00, 1'b0, 1'b0);
        idle(5);
        check("hold_a", bus.out_a, 8'hFF);
        check("hold_b", bus.out_b, 8'h00);
        clear_log();

        // ---------------- gaps mid-frame ----------------
        send_frame(8'hA5, 8'h3C, 1'b1, 5, 11, ^8'hA5, ^8'h3C);
        idle(3);
        check("gap_count", q_a.size(), 1);
        check_pulse("gap", 0, 8'hA5, 8'h3C, 1'b0, 1'b0);
        clear_log();

        // ---------------- sof restart mid-frame ----------------
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_frame(8'h12, 8'h34, 1'b1, 0, 0, ^8'h12, ^8'h34);
        idle(3);
        check("restart_count", q_a.size(), 1);
        check_pulse("restart", 0, 8'h12, 8'h34, 1'b0, 1'b0);
        clear_log();

        // ---------------- reset mid-frame, then unframed data ----------------
        for (int i = 0; i < 9; i++) send_bit(i[0], i == 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.sof      = 1'b0;
        rst          = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_out_a", bus.out_a, 8'h00);
        send_frame(8'h55, 8'hAA, 1'b0, 0, 0, ^8'h55, ^8'hAA);
        idle(4);
        check("rstmid_count", q_a.size(), 0);
        check("rstmid_out_a2", bus.out_a, 8'h00);
        check("rstmid_out_b2", bus.out_b, 8'h00);
        check("rstmid_valid",  bus.out_valid, 1'b0);
        clear_log();

`ifdef DEMUX_PARITY_EN
        // ---------------- parity errors ----------------
        send_frame(8'h03, 8'h07, 1'b1, 0, 0, 1'b0, 1'b0);
        idle(3);
        check("par_count", q_a.size(), 1);
        check_pulse("par", 0, 8'h03, 8'h07, 1'b0, 1'b1);
        clear_log();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_demux_2ch_deser
`default_nettype wire

// File: doc/demux_2ch_deser.md
DEMUX_2CH_DESER -- requirements
Module: demux_2ch_deser

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the word width per channel (legal 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1 bit, the reset; asynchronous, active-high.
REQ-004 The block SHALL have port in_bit, input, 1 bit, the interleaved serial data bit.
REQ-005 The block SHALL have port in_valid, input, 1 bit; in_bit is consumed on a clk edge only when it is high.
REQ-006 The block SHALL have port sof, input, 1 bit, start-of-frame; meaningful only with in_valid.
REQ-007 The block SHALL have port out_a, output, WIDTH bits, the last completed channel-A word.
REQ-008 The block SHALL have port out_b, output, WIDTH bits, the last completed channel-B word.
REQ-009 The block SHALL have port out_valid, output, 1 bit, a one-cycle pulse when out_a/out_b update.
REQ-010 The block SHALL have ports err_a and err_b, outputs, 1 bit each, the parity-error flags, valid with out_valid.
REQ-011 The block SHALL have port sel, output, 1 bit, the current channel select (0=A, 1=B).

Function
REQ-012 The block SHALL be the receive counterpart of the 2-to-1 mux: one interleaved stream is split into channels A and B.
REQ-013 FSM states SHALL be IDLE (wait for sof), RUN (data slots) and PAR (parity slots, present only with the macro).
REQ-014 IDLE: the block SHALL ignore valid bits without sof; in_valid&sof SHALL capture the bit as A bit MSB, set sel=1 and enter RUN.
REQ-015 RUN: each valid bit SHALL go to the channel given by sel, after which sel toggles; each channel shift register SHALL be MSB-first.
REQ-016 Pair counter: it SHALL increment after each B bit and span 0..WIDTH-1.
REQ-017 On the B bit completing pair WIDTH-1, without the macro, the block SHALL load out_a/out_b from the shift registers on the next edge, pulse out_valid for 1 cycle, clear the counter, set sel=0 and stay in RUN for the next frame.
REQ-018 Latency SHALL be 1 clk from the last data-bit edge to out_valid high.
REQ-019 sof with in_valid in any state SHALL restart framing: the partial frame is discarded, no out_valid is produced, and the bit is taken as A MSB.
REQ-020 in_valid low SHALL hold all state; gaps of any length SHALL be legal mid-frame.
REQ-021 Between pulses, out_a/out_b/err_* SHALL hold their last values.

Reset
REQ-022 rst high SHALL asynchronously force state=IDLE, sel=0, counter=0, shift registers=0, out_a=0, out_b=0, out_valid=0, err_a=0 and err_b=0.
REQ-023 Reset asserted mid-frame SHALL discard the frame, with no out_valid after release; the first frame after release SHALL require sof.

Configuration
REQ-024 With macro DEMUX_PARITY_EN defined, a completed data frame SHALL enter PAR, which takes two valid bits: the A parity bit then the B parity bit.
REQ-025 With DEMUX_PARITY_EN, after the B parity bit the block SHALL pulse out_valid, set err_a = XOR(A word, A parity bit) and err_b likewise for B (even parity), then return to RUN with sel=0.
REQ-026 With DEMUX_PARITY_EN, sof during PAR SHALL follow REQ-019.
REQ-027 Without DEMUX_PARITY_EN, the PAR state and its logic SHALL be absent and err_a/err_b SHALL be tied to 0.

Structure
REQ-028 Package demux_pkg SHALL hold the state enum (IDLE/RUN/PAR), default WIDTH and the counter-width constant $clog2(WIDTH).
REQ-029 One sub-module, demux_shift_reg (WIDTH-bit MSB-first shift with enable, asynchronous reset), SHALL be instantiated once per channel.

Verification
REQ-030 WIDTH=8, no macro: sof on the first bit of stream A=0xA5, B=0x3C interleaved -> out_a=0xA5, out_b=0x3C, out_valid high exactly 1 cycle, 1 clk after bit 16.
REQ-031 Two back-to-back frames (A=0x01,B=0x80 then A=0xFF,B=0x00) with sof only on the first -> two pulses with the correct words.
REQ-032 Same frame as REQ-030 with in_valid low for 3 cycles after bits 5 and 11 -> identical result.
REQ-033 sof re-asserted at bit 7 of a frame, then a full frame A=0x12,B=0x34 -> a single pulse carrying 0x12/0x34.
REQ-034 rst pulsed after bit 9, then a frame without sof -> no out_valid and outputs stay 0.
REQ-035 DEMUX_PARITY_EN: A=0x03 with parity 0 and B=0x07 with parity 0 -> err_a=0, err_b=1 with the out_valid pulse.
